// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, R-type funct values and multiply/divide FSM states.
// Divide support is selected by the MULDIV_DIV_EN macro.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } md_state_t;

  // Functs that touch HI/LO and therefore must wait for a busy unit.
  function automatic logic is_md_funct(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 iterative unsigned multiply (shift/add) and divide (restoring) core.
// The divide datapath exists only when MULDIV_DIV_EN is defined.
module md_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef MULDIV_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    count;
  logic             running;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [WIDTH:0]   sum;
`ifdef MULDIV_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
`endif

  // Multiply: lo_q holds the multiplier and shifts right as product bits arrive.
  // Divide: lo_q holds the dividend and collects quotient bits from the right.
  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    hi_nx = sum[WIDTH:1];
    lo_nx = {sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - b_q;
    if (div_q) begin
      if (shifted >= {1'b0, b_q}) begin
        hi_nx = diff;
        lo_nx = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = shifted[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      running <= 1'b0;
      count   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
`endif
    end else if (start) begin
      running <= 1'b1;
      count   <= CW'(WIDTH - 1);
      b_q     <= op_b;
      hi_q    <= '0;
      lo_q    <= op_a;
`ifdef MULDIV_DIV_EN
      div_q   <= is_div;
`endif
    end else if (running) begin
      hi_q <= hi_nx;
      lo_q <= lo_nx;
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done   = running && (count == '0);
  assign res_hi = hi_q;
  assign res_lo = lo_q;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decoder with HI/LO registers and an iterative mult/div unit.
// Define MULDIV_DIV_EN to enable div/divu; otherwise they decode as illegal.
module alu_ctrl_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CNTRL_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               issue_i,
  input  logic [1:0]         alu_op_i,
  input  logic [5:0]         funct_i,
  input  logic [WIDTH-1:0]   rs_val_i,
  input  logic [WIDTH-1:0]   rt_val_i,
  output logic [CNTRL_W-1:0] alu_cntrl_o,
  output logic               illegal_o,
  output logic               md_busy_o,
  output logic               stall_req_o,
  output logic               md_done_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  md_state_t          state;
  logic [CNTRL_W-1:0] cntrl_nx;
  logic               illegal_nx;
  logic               r_type;
  logic               accepted;
  logic               is_mult;
  logic               is_div_op;
  logic               md_start;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               core_done;
  logic [WIDTH-1:0]   core_hi;
  logic [WIDTH-1:0]   core_lo;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;
`ifdef MULDIV_DIV_EN
  logic               div_q;
  logic               rem_neg_q;
  logic               dz_q;
  logic [WIDTH-1:0]   rs_q;
`endif

  always_comb begin
    cntrl_nx   = alu_cntrl_o;
    illegal_nx = 1'b0;
    case (alu_op_i)
      OP_ADD: cntrl_nx = CNTRL_W'(ALU_ADD);
      OP_SUB: cntrl_nx = CNTRL_W'(ALU_SUB);
      OP_OR:  cntrl_nx = CNTRL_W'(ALU_OR);
      default: begin
        case (funct_i)
          F_ADD:  cntrl_nx = CNTRL_W'(ALU_ADD);
          F_SUB:  cntrl_nx = CNTRL_W'(ALU_SUB);
          F_AND:  cntrl_nx = CNTRL_W'(ALU_AND);
          F_OR:   cntrl_nx = CNTRL_W'(ALU_OR);
          F_SLT:  cntrl_nx = CNTRL_W'(ALU_SLT);
          F_XOR:  cntrl_nx = CNTRL_W'(ALU_XOR);
          F_NOR:  cntrl_nx = CNTRL_W'(ALU_NOR);
          F_SLTU: cntrl_nx = CNTRL_W'(ALU_SLTU);
          F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU:
            cntrl_nx = CNTRL_W'(ALU_ADD);
`ifdef MULDIV_DIV_EN
          F_DIV, F_DIVU: cntrl_nx = CNTRL_W'(ALU_ADD);
`endif
          default: illegal_nx = 1'b1;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alu_cntrl_o <= CNTRL_W'(ALU_ADD);
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      alu_cntrl_o <= CNTRL_W'(ALU_ADD);
      illegal_o   <= 1'b0;
    end else if (!stall_i) begin
      alu_cntrl_o <= cntrl_nx;
      illegal_o   <= illegal_nx;
    end
  end

  assign r_type      = (alu_op_i == OP_RTYPE);
  assign stall_req_o = md_busy_o && issue_i && is_md_funct(funct_i);
  assign accepted    = issue_i && !flush_i && !stall_i && !stall_req_o;
  assign is_mult     = (funct_i == F_MULT) || (funct_i == F_MULTU);
`ifdef MULDIV_DIV_EN
  assign is_div_op   = (funct_i == F_DIV) || (funct_i == F_DIVU);
`else
  assign is_div_op   = 1'b0;
`endif
  assign md_start    = accepted && r_type && (state == IDLE) && (is_mult || is_div_op);

  // Core works on magnitudes; even functs (mult/div) are the signed variants.
  assign sign_a = !funct_i[0] && rs_val_i[WIDTH-1];
  assign sign_b = !funct_i[0] && rt_val_i[WIDTH-1];
  assign mag_a  = sign_a ? -rs_val_i : rs_val_i;
  assign mag_b  = sign_b ? -rt_val_i : rt_val_i;

  md_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
`ifdef MULDIV_DIV_EN
    .is_div  (is_div_op),
`endif
    .op_a    (mag_a),
    .op_b    (mag_b),
    .done    (core_done),
    .res_hi  (core_hi),
    .res_lo  (core_lo)
  );

  always_comb begin
    {hi_fix, lo_fix} = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
`ifdef MULDIV_DIV_EN
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    if (div_q) begin
      lo_fix = neg_q ? -core_lo : core_lo;
      hi_fix = rem_neg_q ? -core_hi : core_hi;
      if (dz_q) begin
        lo_fix = '1;
        hi_fix = rs_q;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      md_busy_o <= 1'b0;
      md_done_o <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
      neg_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      rs_q      <= '0;
`endif
    end else begin
      md_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start) begin
            state     <= RUN;
            md_busy_o <= 1'b1;
            neg_q     <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
            div_q     <= is_div_op;
            rem_neg_q <= sign_a;
            dz_q      <= (rt_val_i == '0);
            rs_q      <= rs_val_i;
`endif
          end else if (accepted && r_type && (funct_i == F_MTHI)) begin
            hi_o <= rs_val_i;
          end else if (accepted && r_type && (funct_i == F_MTLO)) begin
            lo_o <= rs_val_i;
          end
        end
        RUN: begin
          if (core_done) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi_o      <= hi_fix;
          lo_o      <= lo_fix;
          md_done_o <= 1'b1;
          md_busy_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench for alu_ctrl_muldiv: decode table, HI/LO timing corners, random mult/div.
// Expectations follow MULDIV_DIV_EN the same way as the design build.
module tb_alu_ctrl_muldiv;

  localparam int unsigned W = 32;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         stall_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         issue_i = 1'b0;
  logic [1:0]   alu_op_i = 2'b00;
  logic [5:0]   funct_i = 6'h00;
  logic [W-1:0] rs_val_i = '0;
  logic [W-1:0] rt_val_i = '0;
  logic [3:0]   alu_cntrl_o;
  logic         illegal_o;
  logic         md_busy_o;
  logic         stall_req_o;
  logic         md_done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic       stall;
    logic       flush;
    logic [3:0] code;
    logic       ill;
  } dec_vec_t;
  dec_vec_t dv[$];

  always #5 clk = ~clk;

  alu_ctrl_muldiv #(
    .WIDTH   (W),
    .CNTRL_W (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .issue_i     (issue_i),
    .alu_op_i    (alu_op_i),
    .funct_i     (funct_i),
    .rs_val_i    (rs_val_i),
    .rt_val_i    (rt_val_i),
    .alu_cntrl_o (alu_cntrl_o),
    .illegal_o   (illegal_o),
    .md_busy_o   (md_busy_o),
    .stall_req_o (stall_req_o),
    .md_done_o   (md_done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add_dec(input logic [1:0] op, input logic [5:0] fn, input logic st,
                                  input logic fl, input logic [3:0] code, input logic ill);
    dec_vec_t v;
    v.op = op; v.fn = fn; v.stall = st; v.flush = fl; v.code = code; v.ill = ill;
    dv.push_back(v);
  endfunction

  // Architectural result of a mult/div as {HI, LO}, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [5:0] fn, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (fn)
      FN_MULT:  r = sa * sb;
      FN_MULTU: r = ua * ub;
      FN_DIV: begin
        if (b == '0) r = {a, 32'hFFFF_FFFF};
        else begin
          r[31:0]  = 32'(sa / sb);
          r[63:32] = 32'(sa % sb);
        end
      end
      FN_DIVU: begin
        if (b == '0) r = {a, 32'hFFFF_FFFF};
        else begin
          r[31:0]  = 32'(ua / ub);
          r[63:32] = 32'(ua % ub);
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic md_issue(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_op_i = 2'b10;
    funct_i  = fn;
    rs_val_i = a;
    rt_val_i = b;
    issue_i  = 1'b1;
    tick();
    issue_i  = 1'b0;
    funct_i  = FN_ADD;
  endtask

  // Issue an operation, check busy/latency, result and single done pulse.
  task automatic run_md(input string name, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] exp);
    int cyc;
    md_issue(fn, a, b);
    check({name, "_busy"}, md_busy_o, 1);
    cyc = 1;
    while (!md_done_o && cyc < 60) begin
      flush_i = (cyc == 3);
      tick();
      cyc++;
    end
    flush_i = 1'b0;
    check({name, "_latency"}, cyc, 34);
    check({name, "_busy_end"}, md_busy_o, 0);
    check({name, "_hilo"}, {hi_o, lo_o}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    tick();
    check({name, "_done_once"}, md_done_o, 0);
  endtask

  initial begin
    int       stalls;
    logic [5:0] fn;
    logic [W-1:0] a;
    logic [W-1:0] b;

    repeat (3) tick();
    check("rst_cntrl", alu_cntrl_o, 4'b0010);
    check("rst_illegal", illegal_o, 0);
    check("rst_busy", md_busy_o, 0);
    check("rst_done", md_done_o, 0);
    check("rst_hilo", {hi_o, lo_o}, 64'h0);
    reset_n = 1'b1;
    tick();

    add_dec(2'b00, 6'h00, 0, 0, 4'b0010, 0);
    add_dec(2'b01, 6'h00, 0, 0, 4'b0110, 0);
    add_dec(2'b11, 6'h00, 0, 0, 4'b0001, 0);
    add_dec(2'b10, 6'b100100, 0, 0, 4'b0000, 0);
    add_dec(2'b10, 6'b100000, 0, 0, 4'b0010, 0);
    add_dec(2'b10, 6'b100010, 0, 0, 4'b0110, 0);
    add_dec(2'b10, 6'b100101, 0, 0, 4'b0001, 0);
    add_dec(2'b10, 6'b101010, 0, 0, 4'b0111, 0);
    add_dec(2'b10, 6'b100110, 0, 0, 4'b1101, 0);
    add_dec(2'b10, 6'b100111, 0, 0, 4'b1100, 0);
    add_dec(2'b10, 6'b101011, 0, 0, 4'b1111, 0);
    add_dec(2'b10, 6'b111111, 0, 0, 4'b1111, 1);
    add_dec(2'b10, 6'b000000, 0, 0, 4'b1111, 1);
    add_dec(2'b10, FN_MULT,   0, 0, 4'b0010, 0);
    add_dec(2'b10, 6'b100110, 1, 0, 4'b0010, 0);
    add_dec(2'b10, 6'b111111, 1, 1, 4'b0010, 0);
    add_dec(2'b10, 6'b100111, 0, 0, 4'b1100, 0);
    add_dec(2'b10, 6'b100110, 0, 0, 4'b1101, 0);
`ifdef MULDIV_DIV_EN
    add_dec(2'b10, FN_DIVU,   0, 0, 4'b0010, 0);
    add_dec(2'b10, 6'b111111, 0, 0, 4'b0010, 1);
    add_dec(2'b10, 6'b100000, 1, 0, 4'b0010, 1);
`else
    add_dec(2'b10, FN_DIVU,   0, 0, 4'b1101, 1);
    add_dec(2'b10, 6'b111111, 0, 0, 4'b1101, 1);
    add_dec(2'b10, 6'b100000, 1, 0, 4'b1101, 1);
`endif
    foreach (dv[i]) begin
      alu_op_i = dv[i].op;
      funct_i  = dv[i].fn;
      stall_i  = dv[i].stall;
      flush_i  = dv[i].flush;
      tick();
      check($sformatf("dec%0d_code", i), alu_cntrl_o, dv[i].code);
      check($sformatf("dec%0d_ill", i), illegal_o, dv[i].ill);
    end
    stall_i = 1'b0;
    flush_i = 1'b0;

    run_md("mult_neg3x7", FN_MULT, -32'sd3, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    run_md("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001);
`ifdef MULDIV_DIV_EN
    run_md("divu_100_7", FN_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    run_md("div_neg7_2", FN_DIV, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_md("div_by0", FN_DIV, -32'sd5, 32'd0, 64'hFFFFFFFB_FFFFFFFF);
    run_md("divu_by0", FN_DIVU, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF);
`endif

    md_issue(FN_MTHI, 32'hCAFE_BABE, 32'd0);
    check("mthi", hi_o, 32'hCAFE_BABE);
    md_issue(FN_MTLO, 32'h0BAD_F00D, 32'd0);
    check("mtlo", lo_o, 32'h0BAD_F00D);
    flush_i = 1'b1;
    md_issue(FN_MTHI, 32'h1111_2222, 32'd0);
    flush_i = 1'b0;
    check("mthi_flushed", hi_o, 32'hCAFE_BABE);

    // mflo presented at N+5 behind a running multiply.
    md_issue(FN_MULT, 32'd5, 32'd6);
    repeat (3) tick();
    issue_i  = 1'b1;
    alu_op_i = 2'b10;
    funct_i  = FN_ADD;
    #1;
    check("stall_nonmd", stall_req_o, 0);
    tick();
    funct_i = FN_MFLO;
    #1;
    stalls = 0;
    while (stall_req_o && stalls < 60) begin
      stalls++;
      tick();
    end
    check("mflo_stall_cycles", stalls, 29);
    check("mflo_lo", lo_o, 32'd30);
    check("mflo_done", md_done_o, 1);
    m_hi = '0;
    m_lo = 32'd30;
    tick();
    issue_i = 1'b0;
    check("mflo_cntrl", alu_cntrl_o, 4'b0010);

    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 5))
        0: fn = FN_MULT;
        1: fn = FN_MULTU;
`ifdef MULDIV_DIV_EN
        2: fn = FN_DIV;
        3: fn = FN_DIVU;
`else
        2: fn = FN_MULT;
        3: fn = FN_MULTU;
`endif
        4: fn = FN_MTHI;
        default: fn = FN_MTLO;
      endcase
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) b = (n % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      if (n % 3 == 1) b = b >> $urandom_range(8, 30);
      if (fn == FN_MTHI || fn == FN_MTLO) begin
        md_issue(fn, a, b);
        if (fn == FN_MTHI) m_hi = a;
        else m_lo = a;
        check($sformatf("rnd%0d_mt", n), {hi_o, lo_o}, {m_hi, m_lo});
      end else begin
        run_md($sformatf("rnd%0d", n), fn, a, b, ref_md(fn, a, b));
      end
    end

    // Reset asserted during cycle N+10 of a running operation.
`ifdef MULDIV_DIV_EN
    md_issue(FN_DIVU, 32'd1000, 32'd3);
`else
    md_issue(FN_MULTU, 32'd1000, 32'd3);
`endif
    repeat (9) tick();
    check("pre_rst_busy", md_busy_o, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_busy", md_busy_o, 0);
    check("midrst_hilo", {hi_o, lo_o}, 64'h0);
    check("midrst_cntrl", alu_cntrl_o, 4'b0010);
    tick();
    check("midrst_stays_idle", md_busy_o, 0);

`ifndef MULDIV_DIV_EN
    md_issue(FN_MTHI, 32'h0000_00AA, 32'd0);
    md_issue(FN_MTLO, 32'h0000_0055, 32'd0);
    md_issue(FN_DIVU, 32'd100, 32'd7);
    check("nodiv_illegal", illegal_o, 1);
    check("nodiv_busy", md_busy_o, 0);
    repeat (3) tick();
    check("nodiv_busy_later", md_busy_o, 0);
    check("nodiv_hilo", {hi_o, lo_o}, 64'h000000AA_00000055);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
